// File: rtl/wb_stage_pkg.sv
// Shared write-back definitions: source-select constants, load-type encodings and stage control word.
package wb_stage_pkg;

    localparam int NSRC_DEF   = 4;
    localparam int RF_ALU_C   = 0;
    localparam int RF_NPC_PC4 = 1;
    // DRAM sits one past the last plain source, so it tracks NSRC.
    localparam int RF_DRAM_RD = NSRC_DEF;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LH  = 3'd1,
        LD_LHU = 3'd2,
        LD_LB  = 3'd3,
        LD_LBU = 3'd4
    } ld_type_e;

    typedef struct packed {
        logic       we;
        logic [4:0] wr;
    } wb_ctl_t;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load alignment and sign/zero extension of the DRAM read word.
module wb_load_ext
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rd,
    input  ld_type_e        ld_type,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] wd
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Half loads ignore addr_lo[0]; a misaligned half is not trapped.
    assign byte_sel = rd[{addr_lo, 3'b000} +: 8];
    assign half_sel = rd[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        wd = rd;
        case (ld_type)
            LD_LB:   wd = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  wd = {{(XLEN-8){1'b0}}, byte_sel};
            LD_LH:   wd = {{(XLEN-16){half_sel[15]}}, half_sel};
            LD_LHU:  wd = {{(XLEN-16){1'b0}}, half_sel};
            default: wd = rd;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back selector with stall/flush, x0 suppression and retire counter.
// Optional load alignment/extension is enabled by defining WB_LOAD_EXT_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NSRC = 4,
    parameter int SELW = $clog2(NSRC + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 m_valid,
    input  logic [SELW-1:0]      m_wd_sel,
    input  logic [NSRC*XLEN-1:0] m_src_data,
    input  logic                 m_rf_we,
    input  logic [4:0]           m_wr,
    input  logic [2:0]           m_ld_type,
    input  logic [1:0]           m_addr_lo,
    input  logic [XLEN-1:0]      dram_rd,
    output logic                 rf_we,
    output logic [4:0]           rf_wr,
    output logic [XLEN-1:0]      rf_wd,
    output logic                 wb_valid,
    output logic [4:0]           fwd_wr,
    output logic [XLEN-1:0]      fwd_wd,
    output logic [31:0]          retire_cnt
);

    localparam logic [SELW-1:0] SEL_DRAM = SELW'(NSRC);

    logic [1:0]      vld_pipe;
    wb_ctl_t         ctl_q;
    logic [SELW-1:0] sel_q;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] src_sel;
    logic [XLEN-1:0] ld_wd;
    logic [31:0]     retire_q;

    assign vld_pipe[0] = m_valid;

    // Selects at or beyond NSRC capture 0 into the data register.
    always_comb begin
        src_sel = '0;
        for (int i = 0; i < NSRC; i++)
            if (m_wd_sel == SELW'(i)) src_sel = m_src_data[i*XLEN +: XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            ctl_q       <= '0;
            sel_q       <= '0;
            data_q      <= '0;
            retire_q    <= '0;
        end else begin
            if (flush) begin
                vld_pipe[1] <= 1'b0;
                ctl_q       <= '0;
                sel_q       <= '0;
                data_q      <= '0;
            end else if (!stall) begin
                vld_pipe[1] <= vld_pipe[0];
                ctl_q       <= '{we: m_rf_we, wr: m_wr};
                sel_q       <= m_wd_sel;
                data_q      <= src_sel;
            end
            if (vld_pipe[1] && !stall) retire_q <= retire_q + 32'd1;
        end
    end

`ifdef WB_LOAD_EXT_EN
    ld_type_e   ld_q;
    logic [1:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_q <= LD_LW;
            lo_q <= '0;
        end else if (flush) begin
            ld_q <= LD_LW;
            lo_q <= '0;
        end else if (!stall) begin
            ld_q <= ld_type_e'(m_ld_type);
            lo_q <= m_addr_lo;
        end
    end

    wb_load_ext #(.XLEN(XLEN)) u_load_ext (
        .rd      (dram_rd),
        .ld_type (ld_q),
        .addr_lo (lo_q),
        .wd      (ld_wd)
    );
`else
    logic unused_ld;
    assign unused_ld = ^{m_ld_type, m_addr_lo};
    assign ld_wd     = dram_rd;
`endif

    // Out-of-range selects never write; a stalled WB never writes.
    assign rf_we      = vld_pipe[1] & ctl_q.we & (ctl_q.wr != 5'd0) & ~stall & (sel_q <= SEL_DRAM);
    assign rf_wr      = ctl_q.wr;
    assign rf_wd      = (sel_q == SEL_DRAM) ? ld_wd : data_q;
    assign wb_valid   = vld_pipe[1];
    assign fwd_wr     = rf_we ? ctl_q.wr : 5'd0;
    assign fwd_wd     = rf_wd;
    assign retire_cnt = retire_q;

endmodule
